cmd_req_rsp: RTL and testbench
==============================

Name: cmd_req_rsp

Overview:
- Responder end of the button command-request handshake: consumes req_rdy/req_vld/req_bus from the request generator and dispatches the captured code as a one-cycle command strobe to the executing logic.
- Waits for completion or timeout, then returns req_ack.
- Optionally reports the result on an LED as a blink count.
- Sits in the FPGA top level between the request generator and the command/debug logic, all in one clock domain.

Parameters:
- CLK_REQ, 12_000: clk frequency in Hz; sets blink timing.
- TMO, 4095: cycles allowed in WAIT before timeout; must be ≥1; counter width is $clog2(TMO+1).

Ports:
- clk  input  1  clock
- rstz  input  1  asynchronous reset, active-low
- req_rdy  input  1  request ready, from generator
- req_vld  input  1  req_bus non-empty, from generator
- req_bus  input  8  request code
- req_ack  output  1  one-cycle acknowledge to generator
- cmd_stb  output  1  one-cycle command strobe
- cmd_code  output  8  latched command code, stable from dispatch until next accept
- cmd_done  input  1  command completed, single-cycle or level
- cmd_err  input  1  command failed; qualified by cmd_done
- rsp_err  output  1  result of last request: 1 = failed, timed out or aborted
- busy  output  1  high in every state except IDLE
- led  output  1  status indicator

Behaviour:
- Reset (async, rstz=0): state=IDLE; req_ack=0, cmd_stb=0, cmd_code=0, rsp_err=0, busy=0, led=0; all counters=0.
- All outputs are registered or Moore-decoded; there is no combinational path from inputs to outputs.

States:
- IDLE:
  - req_rdy=1 & req_vld=1 & req_bus!=0: latch cmd_code<=req_bus, go to DISP.
  - req_rdy=1 & (req_vld=0 | req_bus==0): null request; go directly to ACK; no cmd_stb; rsp_err unchanged.
- DISP:
  - cmd_stb=1 for exactly this one cycle; clear timeout counter; go to WAIT.
  - cmd_done during DISP is ignored.
- WAIT: timeout counter increments each cycle.
  - cmd_done=1: rsp_err<=cmd_err; go to ACK.
  - Else counter==TMO: rsp_err<=1; go to ACK. If cmd_done and timeout occur in the same cycle, cmd_done wins.
  - Else req_rdy=0 (generator reset mid-operation): rsp_err<=1; go to IDLE without ack.
- ACK: req_ack=1 for exactly one cycle; go to HOLD.
- HOLD: wait until req_rdy=0; then go to BLINK (feature on) or IDLE.
  - While in HOLD, req_rdy staying high is never re-accepted.

Timing and rules:
- Latency: req_rdy sampled at edge N → cmd_stb high in cycle N+1.
- cmd_done sampled at edge M → req_ack high in cycle M+1.
- New requests are accepted only in IDLE; a request arriving in any other state waits on req_rdy.
- cmd_code holds its value after completion, for debug readback.

Optional Feature:
- Macro: CMD_RSP_BLINK_EN.
- Defined:
  - BLINK state follows HOLD.
  - On success: led pulses cmd_code[3:0] times, each pulse CLK_REQ/8 cycles on and CLK_REQ/8 off. A count of 0 gives no pulses and one off gap.
  - On error: led is steady on for CLK_REQ/2 cycles.
  - Then go to IDLE; busy stays high throughout BLINK.
  - Reset during BLINK: led=0 immediately.
- Not defined:
  - No BLINK state; HOLD goes to IDLE.
  - led = busy, registered.
  - Blink counters are not synthesized.

Test Plan:
1. Success path: req_bus=8'h23, req_vld=1, req_rdy rises at edge N; cmd_done=1, cmd_err=0 at edge N+5 → cmd_stb in cycle N+1 only, cmd_code=8'h23, req_ack in cycle N+6 only, rsp_err=0; drop req_rdy → IDLE, busy=0.
2. Timeout: TMO=7, no cmd_done → req_ack exactly 8 cycles after WAIT entry, rsp_err=1. Repeat with cmd_done asserted on the timeout cycle → rsp_err=cmd_err.
3. Null request: req_rdy=1, req_bus=0, req_vld=0 → req_ack next cycle, no cmd_stb, rsp_err holds its previous value.
4. Abort: drop req_rdy while in WAIT → no req_ack, rsp_err=1, IDLE next cycle. Assert rstz=0 mid-WAIT → all outputs 0 asynchronously.
5. HOLD/no re-trigger: keep req_rdy=1 for 20 cycles after req_ack → exactly one cmd_stb, busy=1 until req_rdy=0.
6. With CMD_RSP_BLINK_EN, CLK_REQ=16: success with cmd_code=8'h03 → 3 led pulses of 2 cycles on / 2 off, then IDLE. Error case → led on for 8 cycles. Without the macro: led tracks busy, delayed one cycle.

Source files
------------

// File: rtl/cmd_req_rsp_if.sv
// Request/command bundle between the request generator, cmd_req_rsp and the command logic.
// Handshake: the generator raises req_rdy and holds it, with req_vld/req_bus stable, until it
// sees the one-cycle req_ack. It then drops req_rdy. cmd_stb is a single-cycle dispatch, and
// cmd_done (with cmd_err) reports completion.
interface cmd_req_rsp_if;
  logic       req_rdy;
  logic       req_vld;
  logic [7:0] req_bus;
  logic       req_ack;
  logic       cmd_stb;
  logic [7:0] cmd_code;
  logic       cmd_done;
  logic       cmd_err;
  logic       rsp_err;
  logic       busy;
  logic       led;

  modport master (
    output req_rdy, req_vld, req_bus, cmd_done, cmd_err,
    input  req_ack, cmd_stb, cmd_code, rsp_err, busy, led
  );

  modport slave (
    input  req_rdy, req_vld, req_bus, cmd_done, cmd_err,
    output req_ack, cmd_stb, cmd_code, rsp_err, busy, led
  );
endinterface

// File: rtl/cmd_req_rsp.sv
// Responder for the button command request: dispatch, wait for done/timeout, acknowledge.
// Optional LED result blink is enabled by defining CMD_RSP_BLINK_EN.
module cmd_req_rsp #(
  parameter int CLK_REQ = 12_000,
  parameter int TMO     = 4095
) (
  input  logic           clk,
  input  logic           rstz,
  cmd_req_rsp_if.slave   bus,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DISP  = 3'd1,
    WAIT  = 3'd2,
    ACK   = 3'd3,
    HOLD  = 3'd4,
    BLINK = 3'd5
  } state_t;

  localparam int             TW    = $clog2(TMO + 1);
  localparam logic [TW-1:0]  TMO_C = TW'(TMO);

  state_t        state;
  logic [TW-1:0] tmo_cnt;

`ifdef CMD_RSP_BLINK_EN
  localparam int            HALF   = CLK_REQ / 8;
  localparam int            ERR_ON = CLK_REQ / 2;
  localparam int            BW     = $clog2(ERR_ON + 1);
  localparam logic [BW-1:0] HALF_C = BW'(HALF - 1);
  localparam logic [BW-1:0] ERR_C  = BW'(ERR_ON - 1);

  logic [BW-1:0] blink_tmr;
  logic [3:0]    pulses;
`else
  logic unused_clk_req;
  assign unused_clk_req = ^CLK_REQ;
`endif

  assign bus.busy  = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      bus.req_ack  <= 1'b0;
      bus.cmd_stb  <= 1'b0;
      bus.cmd_code <= 8'h00;
      bus.rsp_err  <= 1'b0;
      bus.led      <= 1'b0;
`ifdef CMD_RSP_BLINK_EN
      blink_tmr    <= '0;
      pulses       <= 4'd0;
`endif
    end else begin
      bus.req_ack <= 1'b0;
      bus.cmd_stb <= 1'b0;
`ifndef CMD_RSP_BLINK_EN
      bus.led     <= (state != IDLE);
`endif
      case (state)
        IDLE: begin
          if (bus.req_rdy) begin
            if (bus.req_vld && (bus.req_bus != 8'h00)) begin
              bus.cmd_code <= bus.req_bus;
              bus.cmd_stb  <= 1'b1;
              state        <= DISP;
            end else begin
              // Null request: acknowledge without dispatch, keep the previous result.
              bus.req_ack <= 1'b1;
              state       <= ACK;
            end
          end
        end
        DISP: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (bus.cmd_done) begin
            bus.rsp_err <= bus.cmd_err;
            bus.req_ack <= 1'b1;
            state       <= ACK;
          end else if (tmo_cnt == TMO_C) begin
            bus.rsp_err <= 1'b1;
            bus.req_ack <= 1'b1;
            state       <= ACK;
          end else if (!bus.req_rdy) begin
            bus.rsp_err <= 1'b1;
            state       <= IDLE;
          end
        end
        ACK: state <= HOLD;
        HOLD: begin
          if (!bus.req_rdy) begin
`ifdef CMD_RSP_BLINK_EN
            state <= BLINK;
            if (bus.rsp_err) begin
              bus.led   <= 1'b1;
              blink_tmr <= ERR_C;
              pulses    <= 4'd0;
            end else begin
              // A zero count starts in the off phase and yields a single gap.
              bus.led   <= (bus.cmd_code[3:0] != 4'd0);
              blink_tmr <= HALF_C;
              pulses    <= bus.cmd_code[3:0];
            end
`else
            state <= IDLE;
`endif
          end
        end
`ifdef CMD_RSP_BLINK_EN
        BLINK: begin
          if (blink_tmr != '0) begin
            blink_tmr <= blink_tmr - BW'(1);
          end else if (bus.rsp_err) begin
            bus.led <= 1'b0;
            state   <= IDLE;
          end else if (bus.led) begin
            bus.led   <= 1'b0;
            pulses    <= pulses - 4'd1;
            blink_tmr <= HALF_C;
          end else if (pulses != 4'd0) begin
            bus.led   <= 1'b1;
            blink_tmr <= HALF_C;
          end else begin
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_req_rsp.sv
// Self-checking bench for cmd_req_rsp: vector table, random requests and multi-cycle corner cases.
module tb_cmd_req_rsp;

  localparam int CLK_REQ = 16;
  localparam int TMO     = 7;

  logic       clk  = 1'b0;
  logic       rstz = 1'b0;
  logic [2:0] dbg_state;

  cmd_req_rsp_if bus_if();

  cmd_req_rsp #(.CLK_REQ(CLK_REQ), .TMO(TMO)) dut (
    .clk       (clk),
    .rstz      (rstz),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bus;
    logic       vld;
    int         done_at;   // negedge index after accept where cmd_done pulses; 0 = never
    logic       err;
    int         hold;      // cycles req_rdy stays high after req_ack
    int         exp_ack;   // negedge index where req_ack is seen
    int         exp_stb;
    logic       exp_err;
    logic [7:0] exp_code;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_q[$];
  vec_t       vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every req_ack pops the expected {rsp_err, cmd_code}.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rstz && bus_if.req_ack) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got req_ack=1 expected no ack at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_rsp_err", bus_if.rsp_err, e[8]);
        check("sb_cmd_code", bus_if.cmd_code, e[7:0]);
      end
    end
  end

`ifndef CMD_RSP_BLINK_EN
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rstz) begin
      prev_busy = 1'b0;
    end else begin
      check("led_tracks_busy", bus_if.led, prev_busy);
      prev_busy = bus_if.busy;
    end
  end
`endif

  task automatic run_vec(input vec_t v, output int blen, output int on_n, output int rises);
    int   ack_k, stb_n, stb_k, n;
    logic prev_led;
    ack_k = 0; stb_n = 0; stb_k = 0; n = 0;
    blen = 0; on_n = 0; rises = 0; prev_led = 1'b0;
    @(negedge clk);
    bus_if.req_bus = v.bus;
    bus_if.req_vld = v.vld;
    bus_if.cmd_err = v.err;
    bus_if.req_rdy = 1'b1;
    exp_q.push_back({v.exp_err, v.exp_code});
    for (int k = 1; k <= 40 && ack_k == 0; k++) begin
      @(negedge clk);
      if (bus_if.cmd_stb) begin stb_n++; stb_k = k; end
      if (bus_if.req_ack) ack_k = k;
      bus_if.cmd_done = (k == v.done_at);
    end
    bus_if.cmd_done = 1'b0;
    check("ack_latency", ack_k, v.exp_ack);
    for (int h = 1; h <= v.hold; h++) begin
      @(negedge clk);
      if (bus_if.cmd_stb) stb_n++;
      if (h == 1) check("ack_one_cycle", bus_if.req_ack, 0);
      check("busy_in_hold", bus_if.busy, 1);
    end
    check("stb_count", stb_n, v.exp_stb);
    if (v.exp_stb != 0) check("stb_latency", stb_k, 1);
    bus_if.req_rdy = 1'b0;
    bus_if.req_vld = 1'b0;
`ifdef CMD_RSP_BLINK_EN
    do begin
      @(negedge clk);
      n++;
      if (bus_if.busy) begin
        blen++;
        if (bus_if.led) on_n++;
        if (bus_if.led && !prev_led) rises++;
      end
      prev_led = bus_if.led;
    end while (bus_if.busy && n < 200);
    check("blink_ends", bus_if.busy, 0);
`else
    @(negedge clk);
    check("idle_after_release", bus_if.busy, 0);
    check("state_idle", dbg_state, 0);
`endif
  endtask

  initial begin
    int bl, bo, br;
    // bus  vld done err hold ack stb rsp code
    vecs[0] = '{8'h23, 1'b1, 5, 1'b0,  2,  6, 1, 1'b0, 8'h23};  // success
    vecs[1] = '{8'h00, 1'b1, 0, 1'b0,  1,  1, 0, 1'b0, 8'h23};  // null: code zero
    vecs[2] = '{8'h5A, 1'b1, 0, 1'b0,  1, 10, 1, 1'b1, 8'h5A};  // timeout
    vecs[3] = '{8'h41, 1'b0, 0, 1'b0,  1,  1, 0, 1'b1, 8'h5A};  // null: vld low, err held
    vecs[4] = '{8'h7E, 1'b1, 9, 1'b0,  1, 10, 1, 1'b0, 8'h7E};  // done on timeout cycle wins
    vecs[5] = '{8'h11, 1'b1, 9, 1'b1,  1, 10, 1, 1'b1, 8'h11};  // same, with cmd_err
    vecs[6] = '{8'hC3, 1'b1, 1, 1'b0,  1, 10, 1, 1'b1, 8'hC3};  // done during DISP ignored
    vecs[7] = '{8'h80, 1'b1, 2, 1'b1,  1,  3, 1, 1'b1, 8'h80};  // earliest done, error
    vecs[8] = '{8'h05, 1'b1, 3, 1'b0, 20,  4, 1, 1'b0, 8'h05};  // long hold, no re-trigger
    vecs[9] = '{8'h00, 1'b0, 0, 1'b1,  1,  1, 0, 1'b0, 8'h05};  // null after success

    bus_if.req_rdy  = 1'b0;
    bus_if.req_vld  = 1'b0;
    bus_if.req_bus  = 8'h00;
    bus_if.cmd_done = 1'b0;
    bus_if.cmd_err  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ack", bus_if.req_ack, 0);
    check("rst_cmd_stb", bus_if.cmd_stb, 0);
    check("rst_cmd_code", bus_if.cmd_code, 0);
    check("rst_rsp_err", bus_if.rsp_err, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_led", bus_if.led, 0);
    rstz = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_req_busy", bus_if.busy, 0);

    for (int i = 0; i < 4; i++) begin
      vec_t r;
      r.bus      = 8'($urandom_range(1, 255));
      r.vld      = 1'b1;
      r.done_at  = $urandom_range(2, 9);
      r.err      = 1'($urandom_range(0, 1));
      r.hold     = $urandom_range(1, 3);
      r.exp_ack  = r.done_at + 1;
      r.exp_stb  = 1;
      r.exp_err  = r.err;
      r.exp_code = r.bus;
      run_vec(r, bl, bo, br);
    end

    for (int i = 0; i < 10; i++) run_vec(vecs[i], bl, bo, br);

    // Abort: generator drops req_rdy while waiting.
    @(negedge clk);
    bus_if.req_bus = 8'h33; bus_if.req_vld = 1'b1; bus_if.cmd_err = 1'b0; bus_if.req_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_in_wait", dbg_state, 2);
    bus_if.req_rdy = 1'b0; bus_if.req_vld = 1'b0;
    @(negedge clk);
    check("abort_idle", dbg_state, 0);
    check("abort_busy", bus_if.busy, 0);
    check("abort_rsp_err", bus_if.rsp_err, 1);
    check("abort_no_ack", bus_if.req_ack, 0);
    check("abort_code", bus_if.cmd_code, 8'h33);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of WAIT.
    bus_if.req_bus = 8'h44; bus_if.req_vld = 1'b1; bus_if.req_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", bus_if.busy, 1);
    #2 rstz = 1'b0;
    #1;
    check("async_req_ack", bus_if.req_ack, 0);
    check("async_cmd_stb", bus_if.cmd_stb, 0);
    check("async_cmd_code", bus_if.cmd_code, 0);
    check("async_rsp_err", bus_if.rsp_err, 0);
    check("async_busy", bus_if.busy, 0);
    check("async_led", bus_if.led, 0);
    bus_if.req_rdy = 1'b0; bus_if.req_vld = 1'b0;
    repeat (2) @(negedge clk);
    rstz = 1'b1;
    repeat (2) @(negedge clk);

`ifdef CMD_RSP_BLINK_EN
    begin
      vec_t b;
      b = '{8'h03, 1'b1, 2, 1'b0, 1, 3, 1, 1'b0, 8'h03};
      run_vec(b, bl, bo, br);
      check("blink3_len", bl, 12);
      check("blink3_on", bo, 6);
      check("blink3_pulses", br, 3);
      b = '{8'h27, 1'b1, 2, 1'b1, 1, 3, 1, 1'b1, 8'h27};
      run_vec(b, bl, bo, br);
      check("blink_err_len", bl, 8);
      check("blink_err_on", bo, 8);
      check("blink_err_pulses", br, 1);
      b = '{8'h10, 1'b1, 2, 1'b0, 1, 3, 1, 1'b0, 8'h10};
      run_vec(b, bl, bo, br);
      check("blink0_len", bl, 2);
      check("blink0_on", bo, 0);
    end
    // Reset while the LED is lit must clear it at once.
    @(negedge clk);
    bus_if.req_bus = 8'h05; bus_if.req_vld = 1'b1; bus_if.cmd_err = 1'b0; bus_if.req_rdy = 1'b1;
    exp_q.push_back({1'b0, 8'h05});
    for (int k = 1; k <= 30 && !bus_if.led; k++) begin
      @(negedge clk);
      bus_if.cmd_done = (k == 2);
      if (k == 4) begin bus_if.req_rdy = 1'b0; bus_if.req_vld = 1'b0; end
    end
    bus_if.cmd_done = 1'b0;
    check("blink_started", bus_if.led, 1);
    #2 rstz = 1'b0;
    #1;
    check("blink_reset_led", bus_if.led, 0);
    check("blink_reset_busy", bus_if.busy, 0);
    repeat (2) @(negedge clk);
    rstz = 1'b1;
    repeat (2) @(negedge clk);
`endif

    check("sb_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
